// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first, once/N-times/continuous
module seq_pattern_tx #(
    parameter int   MAX_LEN    = 16,
    parameter int   LEN_W      = 5,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic [7:0]         repeat_in,
    input  logic               start,
    input  logic               stop,
    output logic               x_out,
    output logic               valid,
    output logic               frame_start,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic [7:0]         rep_q,  rep_d;
    logic [LEN_W-1:0]   idx_q;
    logic [7:0]         frames_q;
    logic [3:0]         gap_q;
    logic               x_q, valid_q, fs_q, busy_q, done_q, err_q;

    logic [LEN_W-1:0]   first_idx;
    logic [LEN_W-1:0]   restart_idx;
    logic [LEN_W-1:0]   next_idx;
    logic               len_ok;
    logic               more_frames;

    // Index is always below MAX_LEN when used; a compare loop keeps every index bit live.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] pat,
                                      input logic [LEN_W-1:0]   idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == idx) begin
                b = pat[i];
            end
        end
        return b;
    endfunction

    // Load takes effect before start, so start sees the freshly captured values.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        rep_d = rep_q;
        if (state_q == S_IDLE && load) begin
            pat_d = pattern_in;
            len_d = len_in;
            rep_d = repeat_in;
        end
        first_idx   = len_d - LEN_W'(1);
        restart_idx = len_q - LEN_W'(1);
        next_idx    = idx_q - LEN_W'(1);
        len_ok      = (len_d != '0) && ({1'b0, len_d} <= (LEN_W + 1)'(MAX_LEN));
        more_frames = (rep_q == 8'd0) || (frames_q > 8'd1);
    end

    // Transmit FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            rep_q    <= '0;
            idx_q    <= '0;
            frames_q <= '0;
            gap_q    <= '0;
            x_q      <= IDLE_LEVEL;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fs_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            pat_q  <= pat_d;
            len_q  <= len_d;
            rep_q  <= rep_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state_q  <= S_SEND;
                            idx_q    <= first_idx;
                            frames_q <= rep_d;
                            x_q      <= pick_bit(pat_d, first_idx);
                            valid_q  <= 1'b1;
                            fs_q     <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        x_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (idx_q != '0) begin
                        idx_q <= next_idx;
                        x_q   <= pick_bit(pat_q, next_idx);
                    end else if (more_frames) begin
                        if (rep_q != 8'd0) begin
                            frames_q <= frames_q - 8'd1;
                        end
                        if (GAP_CYCLES > 0) begin
                            state_q <= S_GAP;
                            gap_q   <= 4'(GAP_CYCLES - 1);
                            x_q     <= IDLE_LEVEL;
                            valid_q <= 1'b0;
                        end else begin
                            idx_q <= restart_idx;
                            x_q   <= pick_bit(pat_q, restart_idx);
                            fs_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        x_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        x_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_q == 4'd0) begin
                        state_q <= S_SEND;
                        idx_q   <= restart_idx;
                        x_q     <= pick_bit(pat_q, restart_idx);
                        valid_q <= 1'b1;
                        fs_q    <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out       = x_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - randomized bench for seq_pattern_tx against a frame-timeline model
module tb_seq_pattern_tx;

    localparam int   MAX_LEN = 16;
    localparam int   LEN_W   = 5;
    localparam logic IDLE    = 1'b0;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [MAX_LEN-1:0] pattern_in = '0;
    logic [LEN_W-1:0]   len_in = '0;
    logic [7:0]         repeat_in = '0;

    logic x0, v0, fs0, b0, d0, e0;
    logic x2, v2, fs2, b2, d2, e2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per variant, time offset within the transmission and the frame parameters.
    int          gap_of[2] = '{0, 2};
    bit          m_active[2];
    int          m_t[2], m_len[2], m_rep[2];
    logic [15:0] m_pat[2];
    int          s_len[2], s_rep[2];
    logic [15:0] s_pat[2];
    bit          m_done[2], m_err[2];

    int          cap_n0, cap_n2, fs_cnt0, done_cnt0, vcnt0;
    logic [31:0] cap0, cap2;

    always #5 clk = ~clk;

    seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP_CYCLES(0), .IDLE_LEVEL(IDLE)) u_dut0 (
        .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in), .len_in(len_in),
        .repeat_in(repeat_in), .start(start), .stop(stop), .x_out(x0), .valid(v0),
        .frame_start(fs0), .busy(b0), .done(d0), .err(e0)
    );

    seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP_CYCLES(2), .IDLE_LEVEL(IDLE)) u_dut2 (
        .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in), .len_in(len_in),
        .repeat_in(repeat_in), .start(start), .stop(stop), .x_out(x2), .valid(v2),
        .frame_start(fs2), .busy(b2), .done(d2), .err(e2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_t[k] = 0; m_len[k] = 0; m_rep[k] = 0; m_pat[k] = '0;
            s_len[k] = 0; s_rep[k] = 0; s_pat[k] = '0; m_done[k] = 0; m_err[k] = 0;
        end
    endtask

    // Expected {x, valid, frame_start, busy, done, err} from the frame timeline.
    function automatic logic [5:0] exp_out(input int k);
        int          per, p;
        logic        v, x;
        logic [15:0] pat;
        if (!m_active[k]) return {IDLE, 1'b0, 1'b0, 1'b0, m_done[k], m_err[k]};
        per = m_len[k] + gap_of[k];
        p   = m_t[k] % per;
        pat = m_pat[k];
        v   = (p < m_len[k]);
        x   = v ? pat[m_len[k] - 1 - p] : IDLE;
        return {x, v, (p == 0), 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            m_err[k]  = 0;
            if (m_active[k]) begin
                if (stop) begin
                    m_active[k] = 0;
                    m_done[k]   = 1;
                end else begin
                    m_t[k]++;
                    if (m_rep[k] != 0 &&
                        m_t[k] == m_rep[k] * (m_len[k] + gap_of[k]) - gap_of[k]) begin
                        m_active[k] = 0;
                        m_done[k]   = 1;
                    end
                end
            end else begin
                if (load) begin
                    s_len[k] = int'(len_in);
                    s_rep[k] = int'(repeat_in);
                    s_pat[k] = pattern_in;
                end
                if (start) begin
                    if (s_len[k] >= 1 && s_len[k] <= MAX_LEN) begin
                        m_active[k] = 1;
                        m_t[k]      = 0;
                        m_len[k]    = s_len[k];
                        m_rep[k]    = s_rep[k];
                        m_pat[k]    = s_pat[k];
                    end else begin
                        m_err[k] = 1;
                    end
                end
            end
        end
    endtask

    // One clock: update the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset === 1'b0) model_reset();
        else model_edge();
        @(negedge clk);
        check("dut_gap0_outputs", {26'd0, x0, v0, fs0, b0, d0, e0}, {26'd0, exp_out(0)});
        check("dut_gap2_outputs", {26'd0, x2, v2, fs2, b2, d2, e2}, {26'd0, exp_out(1)});
        if (v0) begin cap0 = {cap0[30:0], x0}; cap_n0++; vcnt0++; end
        if (v2) begin cap2 = {cap2[30:0], x2}; cap_n2++; end
        if (fs0) fs_cnt0++;
        if (d0) done_cnt0++;
    endtask

    task automatic clear_stats();
        cap0 = '0; cap2 = '0; cap_n0 = 0; cap_n2 = 0; fs_cnt0 = 0; done_cnt0 = 0; vcnt0 = 0;
    endtask

    task automatic quiet();
        load = 0; start = 0; stop = 0;
    endtask

    task automatic do_load(input logic [15:0] p, input int l, input int r, input bit st);
        pattern_in = p; len_in = LEN_W'(l); repeat_in = 8'(r); load = 1; start = st;
    endtask

    initial begin
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk);
        check("reset_outputs_gap0", {26'd0, x0, v0, fs0, b0, d0, e0}, 32'd0);
        check("reset_outputs_gap2", {26'd0, x2, v2, fs2, b2, d2, e2}, 32'd0);
        reset = 1;
        step();

        // Single frame, load and start on the same edge.
        clear_stats();
        do_load(16'h0366, 11, 1, 1);
        step(); quiet();
        repeat (14) step();
        check("single_frame_bits", cap0, 32'h366);
        check("single_frame_len", cap_n0, 11);
        check("single_frame_done", done_cnt0, 1);

        // Three back-to-back frames.
        clear_stats();
        do_load(16'h0366, 11, 3, 0);
        step(); quiet(); start = 1;
        step(); quiet();
        repeat (38) step();
        check("rep3_valid_bits", vcnt0, 33);
        check("rep3_frame_starts", fs_cnt0, 3);
        check("rep3_done_pulses", done_cnt0, 1);

        // Gap variant: two frames of 1011 separated by idle cycles.
        clear_stats();
        do_load(16'h000b, 4, 2, 1);
        step(); quiet();
        repeat (14) step();
        check("gap2_bits", cap2, 32'hbb);
        check("gap2_len", cap_n2, 8);

        // Continuous, stop during the third bit of the second frame.
        clear_stats();
        do_load(16'h0366, 11, 0, 1);
        step(); quiet();
        repeat (13) step();
        stop = 1;
        step(); quiet();
        repeat (4) step();
        check("stop_done_pulses", done_cnt0, 1);

        // Illegal lengths are rejected.
        do_load(16'h00ff, 0, 1, 1);
        step(); quiet(); step();
        do_load(16'h00ff, 17, 1, 1);
        step(); quiet(); step();

        // Second start/load mid-frame is ignored.
        do_load(16'h00a5, 8, 1, 1);
        step(); quiet();
        repeat (3) step();
        do_load(16'h0001, 3, 5, 1);
        step(); quiet();
        repeat (8) step();

        // Reset mid-frame clears outputs at once.
        clear_stats();
        do_load(16'h0366, 11, 2, 1);
        step(); quiet();
        repeat (4) step();
        reset = 0;
        #1;
        check("async_reset_gap0", {26'd0, x0, v0, fs0, b0, d0, e0}, 32'd0);
        check("async_reset_gap2", {26'd0, x2, v2, fs2, b2, d2, e2}, 32'd0);
        step();
        reset = 1;
        repeat (3) step();
        check("reset_no_done", done_cnt0, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            quiet();
            reset = 1;
            if ($urandom_range(0, 7) == 0)
                do_load(16'($urandom), $urandom_range(0, 18), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 5) == 0) start = 1;
            if ($urandom_range(0, 39) == 0) stop = 1;
            if ($urandom_range(0, 299) == 0) reset = 0;
            step();
        end
        quiet();
        reset = 1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
